// File: rtl/io_arb_pkg.sv
// ----------------------------------------------------------------------------
// io_arb_pkg
// Shared types and constants for the I/O register bus arbiter.
//   arb_state_t  : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   IO_ADDR_W    : I/O register address width
//   IO_IDLE_ADDR : address driven on the bus whenever no access is active
//   MAX_REQ      : largest supported number of bus masters
//   IDX_W        : width of a requester index (sized for MAX_REQ)
// ----------------------------------------------------------------------------
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int         IO_ADDR_W    = 6;
    localparam logic [5:0] IO_IDLE_ADDR = 6'h00;
    localparam int         MAX_REQ      = 4;
    localparam int         IDX_W        = $clog2(MAX_REQ);

endpackage

// File: rtl/io_rr_pick.sv
// ----------------------------------------------------------------------------
// io_rr_pick
// Combinational round-robin picker. Scans requesters starting at (last+1)
// mod NREQ with wrap and reports the first one with its request high.
//   i_req      : request vector
//   i_last     : index of the most recent winner
//   o_win_oh   : one-hot winner (all zero when no request)
//   o_win_idx  : index of the winner
//   o_any      : at least one request is high
// ----------------------------------------------------------------------------
module io_rr_pick
    import io_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_win_oh,
    output logic [IDX_W-1:0] o_win_idx,
    output logic             o_any
);

    int w_cand;

    // Walk from the farthest candidate (last itself) back to the nearest
    // (last+1); later hits overwrite earlier ones, so the nearest requester
    // after last ends up as the winner without needing an early exit.
    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        o_any     = |i_req;
        w_cand    = 0;
        for (int i = NREQ; i >= 1; i--) begin
            w_cand = (int'(i_last) + i) % NREQ;
            if (i_req[w_cand]) begin
                o_win_oh         = '0;
                o_win_oh[w_cand] = 1'b1;
                o_win_idx        = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/io_bus_arb.sv
// ----------------------------------------------------------------------------
// io_bus_arb
// Round-robin arbiter/sequencer sharing the I/O register bus between up to
// four masters. One access per transaction: IDLE (pick) -> ACCESS (strobe
// for one cycle) -> RESP (ack + response) -> IDLE. All outputs registered.
//   cp2, ireset          : clock, synchronous active-high reset
//   req/req_we           : per-requester request level and write flag
//   req_addr/req_wdata   : packed per-requester address and write data
//   gnt/ack              : one-hot ownership and one-cycle completion pulse
//   rsp_rdata/rsp_err    : response data, error when no slave answered a read
//   IO_Addr/io_wdata     : bus address and write data to slaves
//   iore/iowe            : bus read/write strobes
//   bus_rdata/bus_rden   : OR-merged slave read data and read enable
// ----------------------------------------------------------------------------
module io_bus_arb
    import io_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = IO_ADDR_W
) (
    input  logic                   cp2,
    input  logic                   ireset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*8-1:0]      req_wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      IO_Addr,
    output logic [7:0]             io_wdata,
    output logic                   iore,
    output logic                   iowe,
    input  logic [7:0]             bus_rdata,
    input  logic                   bus_rden
);

    arb_state_t        r_state, w_next;
    logic [IDX_W-1:0]  r_last;
    logic [NREQ-1:0]   r_gnt, r_ack;
    logic [7:0]        r_rdata, r_wdata;
    logic              r_err, r_iore, r_iowe;
    logic [ADDR_W-1:0] r_addr;

    logic [NREQ-1:0]   w_win_oh;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_any;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_wdata;

    io_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req     (req),
        .i_last    (r_last),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

    // Payload mux driven by the one-hot winner, so no index ever points
    // past the packed vectors when NREQ is below MAX_REQ.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_oh[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge cp2) begin
        if (ireset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The bus output registers double as the payload latch: they are loaded
    // at the pick and are only visible during ACCESS.
    always_ff @(posedge cp2) begin
        if (ireset) begin
            r_last  <= IDX_W'(NREQ - 1);
            r_gnt   <= '0;
            r_ack   <= '0;
            r_rdata <= 8'h00;
            r_err   <= 1'b0;
            r_addr  <= ADDR_W'(IO_IDLE_ADDR);
            r_wdata <= 8'h00;
            r_iore  <= 1'b0;
            r_iowe  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_win_oh;
                        r_last  <= w_win_idx;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_iowe  <= w_sel_we;
                        r_iore  <= ~w_sel_we;
                    end
                end
                ACCESS: begin
                    r_addr  <= ADDR_W'(IO_IDLE_ADDR);
                    r_wdata <= 8'h00;
                    r_iowe  <= 1'b0;
                    r_iore  <= 1'b0;
                    r_ack   <= r_gnt;
                    // r_iore still marks the access as a read on this edge.
                    if (r_iore) begin
                        r_rdata <= bus_rden ? bus_rdata : 8'h00;
                        r_err   <= ~bus_rden;
                    end else begin
                        r_rdata <= 8'h00;
                        r_err   <= 1'b0;
                    end
                end
                RESP: begin
                    r_ack <= '0;
                    r_gnt <= '0;
                end
                default: begin
                    r_ack <= '0;
                    r_gnt <= '0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign IO_Addr   = r_addr;
    assign io_wdata  = r_wdata;
    assign iore      = r_iore;
    assign iowe      = r_iowe;

endmodule

// File: tb/tb_io_bus_arb.sv
module tb_io_bus_arb;

    logic cp2 = 1'b0;
    logic ireset;
    always #5 cp2 = ~cp2;

    // Two-requester instance
    logic [1:0]  req2, req_we2, gnt2, ack2;
    logic [11:0] req_addr2;
    logic [15:0] req_wdata2;
    logic [7:0]  rsp_rdata2, io_wdata2, bus_rdata2;
    logic        rsp_err2, iore2, iowe2, bus_rden2;
    logic [5:0]  IO_Addr2;

    // Four-requester instance
    logic [3:0]  req4, req_we4, gnt4, ack4;
    logic [23:0] req_addr4;
    logic [31:0] req_wdata4;
    logic [7:0]  rsp_rdata4, io_wdata4, bus_rdata4;
    logic        rsp_err4, iore4, iowe4, bus_rden4;
    logic [5:0]  IO_Addr4;

    io_bus_arb #(.NREQ(2), .ADDR_W(6)) u_dut2 (
        .cp2(cp2), .ireset(ireset), .req(req2), .req_we(req_we2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .gnt(gnt2), .ack(ack2),
        .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .IO_Addr(IO_Addr2),
        .io_wdata(io_wdata2), .iore(iore2), .iowe(iowe2),
        .bus_rdata(bus_rdata2), .bus_rden(bus_rden2)
    );

    io_bus_arb #(.NREQ(4), .ADDR_W(6)) u_dut4 (
        .cp2(cp2), .ireset(ireset), .req(req4), .req_we(req_we4),
        .req_addr(req_addr4), .req_wdata(req_wdata4), .gnt(gnt4), .ack(ack4),
        .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4), .IO_Addr(IO_Addr4),
        .io_wdata(io_wdata4), .iore(iore4), .iowe(iowe4),
        .bus_rdata(bus_rdata4), .bus_rden(bus_rden4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cp2);
        #1;
    endtask

    typedef struct {
        int         who;
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic       rden;
        logic [7:0] bdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g2;
        logic [1:0] exp_a2;
        logic       prev_strobe;
        int         ph, owner;

        vecs[0] = '{who: 0, we: 1'b1, addr: 6'h05, wdata: 8'hA5, rden: 1'b0, bdata: 8'h00, exp_rdata: 8'h00, exp_err: 1'b0};
        vecs[1] = '{who: 1, we: 1'b0, addr: 6'h04, wdata: 8'h00, rden: 1'b1, bdata: 8'h3C, exp_rdata: 8'h3C, exp_err: 1'b0};
        vecs[2] = '{who: 0, we: 1'b0, addr: 6'h3F, wdata: 8'h00, rden: 1'b0, bdata: 8'h77, exp_rdata: 8'h00, exp_err: 1'b1};
        vecs[3] = '{who: 1, we: 1'b1, addr: 6'h2A, wdata: 8'h5A, rden: 1'b1, bdata: 8'hFF, exp_rdata: 8'h00, exp_err: 1'b0};
        vecs[4] = '{who: 0, we: 1'b0, addr: 6'h10, wdata: 8'h00, rden: 1'b1, bdata: 8'hC3, exp_rdata: 8'hC3, exp_err: 1'b0};

        ireset = 1'b1;
        req2 = '0; req_we2 = '0; req_addr2 = '0; req_wdata2 = '0;
        bus_rdata2 = '0; bus_rden2 = 1'b0;
        req4 = '0; req_we4 = '0; req_addr4 = '0; req_wdata4 = '0;
        bus_rdata4 = '0; bus_rden4 = 1'b0;
        tick();
        tick();
        chk("reset_outputs2", {gnt2, ack2, rsp_rdata2, rsp_err2, IO_Addr2, io_wdata2, iore2, iowe2}, 64'd0);
        chk("reset_outputs4", {gnt4, ack4, rsp_rdata4, rsp_err4, IO_Addr4, io_wdata4, iore4, iowe4}, 64'd0);
        ireset = 1'b0;

        // Single-requester transactions from the vector table
        for (int v = 0; v < 5; v++) begin
            req_addr2 = '0; req_wdata2 = '0; req_we2 = '0;
            req_addr2[vecs[v].who*6 +: 6]  = vecs[v].addr;
            req_wdata2[vecs[v].who*8 +: 8] = vecs[v].wdata;
            req_we2[vecs[v].who]           = vecs[v].we;
            req2 = 2'b01 << vecs[v].who;
            tick(); // ACCESS
            chk($sformatf("v%0d_gnt", v), gnt2, 2'b01 << vecs[v].who);
            chk($sformatf("v%0d_addr", v), IO_Addr2, vecs[v].addr);
            chk($sformatf("v%0d_wdata", v), io_wdata2, vecs[v].we ? vecs[v].wdata : 8'h00);
            chk($sformatf("v%0d_strobes", v), {iowe2, iore2}, {vecs[v].we, ~vecs[v].we});
            chk($sformatf("v%0d_ack_early", v), ack2, 2'b00);
            bus_rden2 = vecs[v].rden;
            bus_rdata2 = vecs[v].bdata;
            tick(); // RESP
            chk($sformatf("v%0d_ack", v), ack2, 2'b01 << vecs[v].who);
            chk($sformatf("v%0d_rsp_rdata", v), rsp_rdata2, vecs[v].exp_rdata);
            chk($sformatf("v%0d_rsp_err", v), rsp_err2, vecs[v].exp_err);
            chk($sformatf("v%0d_resp_bus_idle", v), {iowe2, iore2, IO_Addr2, io_wdata2}, 16'd0);
            chk($sformatf("v%0d_gnt_held", v), gnt2, 2'b01 << vecs[v].who);
            req2 = '0;
            bus_rden2 = 1'b0;
            bus_rdata2 = 8'h00;
            tick(); // IDLE
            chk($sformatf("v%0d_idle_ack_gnt", v), {ack2, gnt2}, 4'b0000);
            chk($sformatf("v%0d_rsp_hold", v), {rsp_rdata2, rsp_err2}, {vecs[v].exp_rdata, vecs[v].exp_err});
        end

        // Both requesters held high from reset: grants alternate 0,1,0,1
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        req_we2 = 2'b00;
        req_addr2 = {6'h22, 6'h11};
        req_wdata2 = '0;
        bus_rden2 = 1'b1;
        bus_rdata2 = 8'h99;
        req2 = 2'b11;
        prev_strobe = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            ph = (c - 1) % 3;
            owner = ((c - 1) / 3) % 2;
            exp_g2 = (ph < 2) ? (2'b01 << owner) : 2'b00;
            exp_a2 = (ph == 1) ? (2'b01 << owner) : 2'b00;
            chk($sformatf("rr_gnt_c%0d", c), gnt2, exp_g2);
            chk($sformatf("rr_ack_c%0d", c), ack2, exp_a2);
            chk($sformatf("rr_no_b2b_c%0d", c), prev_strobe & (iore2 | iowe2), 1'b0);
            if (ph == 0)
                chk($sformatf("rr_addr_c%0d", c), IO_Addr2, owner == 0 ? 6'h11 : 6'h22);
            prev_strobe = iore2 | iowe2;
        end
        req2 = 2'b00;
        bus_rden2 = 1'b0;
        bus_rdata2 = 8'h00;
        tick();

        // Reset during ACCESS of a write abandons the transaction
        req_we2 = 2'b01;
        req_addr2 = {6'h00, 6'h15};
        req_wdata2 = {8'h00, 8'h66};
        req2 = 2'b01;
        tick();
        chk("rst_pre_iowe", iowe2, 1'b1);
        ireset = 1'b1;
        req2 = 2'b11;
        tick();
        chk("rst_mid_strobe_gnt_ack", {iowe2, iore2, gnt2, ack2}, 6'd0);
        ireset = 1'b0;
        tick();
        chk("rst_after_gnt0", gnt2, 2'b01);
        chk("rst_after_write", {iowe2, IO_Addr2, io_wdata2}, {1'b1, 6'h15, 8'h66});
        tick();
        chk("rst_after_ack0", ack2, 2'b01);
        chk("rst_after_rsp", {rsp_rdata2, rsp_err2}, 9'd0);
        req2 = 2'b10;
        tick(); // IDLE
        chk("rst_idle_no_ack", ack2, 2'b00);
        tick(); // ACCESS for requester 1 (read, no slave)
        chk("rst_r1_gnt", gnt2, 2'b10);
        chk("rst_r1_iore", {iore2, iowe2}, 2'b10);
        tick();
        chk("rst_r1_ack", ack2, 2'b10);
        chk("rst_r1_err", {rsp_rdata2, rsp_err2}, {8'h00, 1'b1});
        req2 = 2'b00;
        tick();

        // NREQ=4: after last=1, request vector 1010 grants 3 before 1
        req_we4 = 4'b0000;
        req_addr4 = {6'h33, 6'h00, 6'h31, 6'h00};
        bus_rden4 = 1'b1;
        bus_rdata4 = 8'h42;
        req4 = 4'b0010;
        tick();
        chk("n4_first_gnt1", gnt4, 4'b0010);
        tick();
        chk("n4_first_ack1", ack4, 4'b0010);
        chk("n4_first_rdata", rsp_rdata4, 8'h42);
        req4 = 4'b1010;
        tick(); // IDLE
        tick(); // ACCESS
        chk("n4_gnt3_before_1", gnt4, 4'b1000);
        chk("n4_addr3", IO_Addr4, 6'h33);
        tick();
        chk("n4_ack3", ack4, 4'b1000);
        req4 = 4'b0010;
        tick(); // IDLE
        tick(); // ACCESS
        chk("n4_then_gnt1", gnt4, 4'b0010);
        chk("n4_addr1", IO_Addr4, 6'h31);
        tick();
        chk("n4_then_ack1", ack4, 4'b0010);
        req4 = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
